// File: rtl/vproc_bridge_pkg.sv
// vproc_bridge_pkg
// Shared types and constants for the VProc bus bridge.
//   bridge_state_t  : bridge FSM state encoding
//   BRIDGE_ERR_DATA : read data returned when a request times out
package vproc_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    ACK  = 2'd3
  } bridge_state_t;

  localparam logic [31:0] BRIDGE_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/vproc_bridge_timer.sv
// vproc_bridge_timer
// Saturating watchdog counter for the bus bridge. Only compiled when
// VPROC_BRIDGE_TIMEOUT_EN is defined; the default build has no timer.
// Ports:
//   clk_sys  in  clock
//   rst_b    in  asynchronous active-low reset
//   clr      in  synchronous clear (wins over en)
//   en       in  count enable
//   expired  out count has reached LIMIT (holds until cleared)
`ifdef VPROC_BRIDGE_TIMEOUT_EN
module vproc_bridge_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/vproc_bus_bridge.sv
// vproc_bus_bridge
// Converts VProc level-held RD/WE requests into a registered valid/ready
// request channel, waits for a single-cycle response pulse, and returns a
// one-cycle WRAck/RDAck (with DataIn on reads) back to VProc.
// Optional feature macro: VPROC_BRIDGE_TIMEOUT_EN (watchdog on REQ/RSP).
// Ports:
//   Clk, nReset                 clock, async active-low reset
//   Addr, WE, RD, DataOut       VProc request side
//   DataIn, WRAck, RDAck        VProc response side
//   Update, UpdateResponse      VProc delta-cycle handshake (combinational echo)
//   MReqValid/Ready/We/Addr/WData  request channel to target
//   MRspValid, MRspData         response pulse from target
//   Error                       sticky protocol/timeout error
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for WE|RD from VProc
// REQ   | MReqValid high, holding fields until MReqReady
// RSP   | request accepted, waiting for MRspValid
// ACK   | response in, issue one-cycle WRAck/RDAck next cycle
module vproc_bus_bridge
  import vproc_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic                  WE,
  input  logic                  RD,
  input  logic [DATA_WIDTH-1:0] DataOut,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  WRAck,
  output logic                  RDAck,
  input  logic                  Update,
  output logic                  UpdateResponse,
  output logic                  MReqValid,
  input  logic                  MReqReady,
  output logic                  MReqWe,
  output logic [ADDR_WIDTH-1:0] MReqAddr,
  output logic [DATA_WIDTH-1:0] MReqWData,
  input  logic                  MRspValid,
  input  logic [DATA_WIDTH-1:0] MRspData,
  output logic                  Error
);

  bridge_state_t         state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wrack_q, wrack_d;
  logic                  rdack_q, rdack_d;
  logic                  err_q, err_d;
  logic                  tmo_expired;

  // VProc waits on this within the same time step; must stay unregistered.
  assign UpdateResponse = Update;

`ifdef VPROC_BRIDGE_TIMEOUT_EN
  logic tmo_clr, tmo_en;

  // REQ is only reachable from IDLE, so clearing in IDLE restarts the
  // count on every new request.
  assign tmo_clr = (state_q == IDLE);
  assign tmo_en  = (state_q == REQ) || (state_q == RSP);

  vproc_bridge_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_sys (Clk),
    .rst_b   (nReset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign tmo_expired    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wrack_d = 1'b0;
    rdack_d = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        // While the ack pulse is still high VProc has not yet seen it and
        // is still presenting the old request; ignore it for that cycle.
        if ((WE || RD) && !wrack_q && !rdack_q) begin
          addr_d  = Addr;
          wdata_d = DataOut;
          we_d    = WE;
          valid_d = 1'b1;
          state_d = REQ;
          if (WE && RD) begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (MReqReady) begin
          valid_d = 1'b0;
          state_d = RSP;
        end else if (tmo_expired) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = ACK;
          if (!we_q) begin
            rdata_d = DATA_WIDTH'(BRIDGE_ERR_DATA);
          end
        end
      end
      RSP: begin
        if (MRspValid) begin
          if (!we_q) begin
            rdata_d = MRspData;
          end
          state_d = ACK;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ACK;
          if (!we_q) begin
            rdata_d = DATA_WIDTH'(BRIDGE_ERR_DATA);
          end
        end
      end
      ACK: begin
        wrack_d = we_q;
        rdack_d = !we_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A response with nothing outstanding is dropped and flagged.
    if (MRspValid && (state_q != RSP)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wrack_q <= 1'b0;
      rdack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wrack_q <= wrack_d;
      rdack_q <= rdack_d;
      err_q   <= err_d;
    end
  end

  assign MReqValid = valid_q;
  assign MReqWe    = we_q;
  assign MReqAddr  = addr_q;
  assign MReqWData = wdata_q;
  assign DataIn    = rdata_q;
  assign WRAck     = wrack_q;
  assign RDAck     = rdack_q;
  assign Error     = err_q;

endmodule

// File: doc/vproc_bus_bridge.md
# vproc_bus_bridge

Downstream stage of the VProc virtual processor. It converts VProc's level-held RD/WE bus requests, including address-incrementing bursts, into a registered valid/ready request channel with a single-cycle response pulse. It then returns DataIn plus a one-cycle WRAck/RDAck to VProc. It also closes VProc's delta-cycle Update/UpdateResponse loop.

## Interface
- ADDR_WIDTH, 32: width of Addr and MReqAddr.
- DATA_WIDTH, 32: width of all data buses.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with the timeout feature.
- Clk  in  1  system clock; all logic on posedge.
- nReset  in  1  reset, asynchronous and active-low.
- Addr  in  ADDR_WIDTH  VProc address.
- WE  in  1  VProc write request, level-held until acked.
- RD  in  1  VProc read request, level-held until acked.
- DataOut  in  DATA_WIDTH  VProc write data.
- DataIn  out  DATA_WIDTH  read data to VProc.
- WRAck  out  1  write acknowledge, one-cycle pulse.
- RDAck  out  1  read acknowledge, one-cycle pulse.
- Update  in  1  VProc update toggle.
- UpdateResponse  out  1  echo of Update.
- MReqValid  out  1  request valid.
- MReqReady  in  1  request accepted by target.
- MReqWe  out  1  1 = write, 0 = read.
- MReqAddr  out  ADDR_WIDTH  request address.
- MReqWData  out  DATA_WIDTH  request write data.
- MRspValid  in  1  response pulse; no backpressure.
- MRspData  in  DATA_WIDTH  read response data.
- Error  out  1  sticky error flag; cleared only by reset.

## Operation
- UpdateResponse = Update, combinational with no register. VProc blocks on its change within the same time step, so this path must stay combinational.
- FSM states are IDLE, REQ, RSP and ACK. The state register is reset to IDLE.
- IDLE: when WE|RD is sampled at a posedge, capture Addr, DataOut and WE into MReqAddr, MReqWData and MReqWe. Set MReqValid and go to REQ. If WE and RD are both 1, treat the access as a write and set Error.
- REQ: hold MReqValid and the captured fields until MReqReady is sampled as 1. Then clear MReqValid and go to RSP.
- RSP: wait for MRspValid, which is required for both reads and writes. On MRspValid, load DataIn with MRspData (reads only; DataIn is unchanged on writes). Go to ACK.
- ACK: assert WRAck or RDAck, matching the captured MReqWe, for exactly one cycle. Then go to IDLE unconditionally.
- A burst is a sequence of ordinary single requests. VProc changes Addr and DataOut on the same edge that samples the ack, so the IDLE cycle after ACK always sees the fresh values.
- If MRspValid arrives outside RSP, drop it and set Error.
- Reset values: MReqValid=0, MReqWe=0, MReqAddr=0, MReqWData=0, DataIn=0, WRAck=0, RDAck=0, Error=0.
- Asserting reset mid-transaction aborts it immediately. MReqValid drops asynchronously and no ack is issued. VProc re-presents its held request after reset is released.

## Timing
- Edge n: WE/RD first sampled in IDLE. MReqValid is high after edge n.
- With MReqReady tied high, it is sampled at n+1.
- The earliest MRspValid is sampled at n+2.
- The ack is high between edges n+3 and n+4, and VProc samples it at n+4.
- Minimum latency is 4 clocks from request to sampled ack. Back-to-back accesses complete every 5 clocks.
- MReqValid, once asserted, never falls without MReqReady, except on reset.

## Configuration
- VPROC_BRIDGE_TIMEOUT_EN defined:
  - A cycle counter runs in REQ and RSP and clears on entry to REQ.
  - When it reaches TIMEOUT_CYCLES, force ACK with DataIn = 32'hDEADBEEF on reads, clear MReqValid, and set Error.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter. The bridge waits indefinitely and TIMEOUT_CYCLES is ignored.

## Structure
- Package vproc_bridge_pkg holds:
  - enum bridge_state_t {IDLE, REQ, RSP, ACK};
  - the constant BRIDGE_ERR_DATA = 32'hDEADBEEF.
- Sub-module vproc_bridge_timer (counter with clear/enable/expired) is instantiated only under VPROC_BRIDGE_TIMEOUT_EN.

## Test plan
- Single write: WE=1, Addr=0x100, DataOut=0xA5A5_0001, MReqReady tied 1, response one cycle later -> MReqAddr=0x100 and MReqWData=0xA5A5_0001 for one valid cycle; WRAck pulses for one cycle 4 clocks after the request.
- Single read with backpressure: RD=1, Addr=0x200, MReqReady low for 3 cycles, MRspData=0x1234_5678 -> MReqValid held 4 cycles with stable fields; DataIn=0x1234_5678 when RDAck pulses.
- 4-word write burst: VProc increments Addr 0x0 to 0xC -> 4 requests at 0x0, 0x4, 0x8, 0xC, spaced 5 clocks apart; 4 WRAck pulses; Error=0.
- Protocol errors: WE=RD=1 -> write issued and Error=1. Stray MRspValid while in IDLE -> ignored and Error=1.
- Reset asserted in RSP -> MReqValid=0, acks=0, state IDLE immediately; after release, the held request is reissued.
- With VPROC_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, RD=1 and no response -> RDAck after 16 cycles, DataIn=0xDEADBEEF, Error=1.
